// File: rtl/freelist_gen.sv
// freelist_gen: physical-register free list with per-lane lowest-index allocation and checkpoint/recover.
// Optional double-free detection is built when FREELIST_DOUBLE_FREE_CHK_EN is defined.
module freelist_gen #(
    parameter int RENAME_W = 3,
    parameter int N_PRF    = 64,
    parameter int N_ARCH   = 32,
    parameter int N_CP     = 4,
    localparam int IDX_W   = $clog2(N_PRF),
    localparam int CP_W    = $clog2(N_CP),
    localparam int CNT_W   = $clog2(N_PRF + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [RENAME_W-1:0]       prf_req,
    output logic [RENAME_W*IDX_W-1:0] prf_out,
    output logic                      allocatable,
    input  logic [RENAME_W-1:0]       prf_replace_valid,
    input  logic [RENAME_W*IDX_W-1:0] prf_replace,
    input  logic                      check,
    input  logic [CP_W-1:0]           check_idx,
    input  logic                      recover,
    input  logic [CP_W-1:0]           recover_idx,
    output logic [CNT_W-1:0]          free_count,
    output logic                      err_double_free
);

    function automatic logic [CNT_W-1:0] popcount_prf(input logic [N_PRF-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_PRF; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

    // Architectural registers own PRF 0..N_ARCH-1 out of reset; everything above is free.
    function automatic logic [N_PRF-1:0] reset_map();
        logic [N_PRF-1:0] m;
        for (int i = 0; i < N_PRF; i++) begin
            m[i] = (i >= N_ARCH);
        end
        return m;
    endfunction

    logic [N_PRF-1:0] free_q;
    logic [N_PRF-1:0] free_d;
    logic [N_PRF-1:0] snap_q [N_CP];
    logic [N_PRF-1:0] snap_d [N_CP];
    logic [CNT_W-1:0] free_count_q;
    logic [CNT_W-1:0] free_count_d;

    logic [N_PRF-1:0] avail_s;
    logic [N_PRF-1:0] grant_mask_s;
    logic [N_PRF-1:0] free_mask_s;
    logic [31:0]      req_cnt_s;
    logic             found_s;
    logic [IDX_W-1:0] rel_idx_s;

    // Per-lane grant: each requesting lane takes the lowest index not already given to a lower lane.
    always_comb begin
        avail_s      = free_q;
        grant_mask_s = '0;
        prf_out      = '0;
        req_cnt_s    = 32'd0;
        found_s      = 1'b0;
        for (int l = 0; l < RENAME_W; l++) begin
            found_s = 1'b0;
            if (prf_req[l]) begin
                req_cnt_s = req_cnt_s + 32'd1;
                for (int i = 0; i < N_PRF; i++) begin
                    if (avail_s[i] && !found_s) begin
                        found_s                    = 1'b1;
                        avail_s[i]                 = 1'b0;
                        grant_mask_s[i]            = 1'b1;
                        prf_out[l*IDX_W +: IDX_W]  = IDX_W'(i);
                    end else begin
                        found_s = found_s;
                    end
                end
            end else begin
                found_s = 1'b0;
            end
        end
    end

    assign allocatable = (req_cnt_s <= 32'(free_count_q)) && !recover;

    // Frees collapse into one mask, so duplicate lanes naturally count once and PRF 0 is dropped.
    always_comb begin
        free_mask_s = '0;
        rel_idx_s   = '0;
        for (int l = 0; l < RENAME_W; l++) begin
            rel_idx_s = prf_replace[l*IDX_W +: IDX_W];
            if (prf_replace_valid[l] && (rel_idx_s != '0) && (int'(rel_idx_s) < N_PRF)) begin
                free_mask_s[rel_idx_s] = 1'b1;
            end else begin
                free_mask_s = free_mask_s;
            end
        end
    end

    // Next-state bitmaps: frees reach every snapshot; recover wins over allocation and check.
    always_comb begin
        for (int c = 0; c < N_CP; c++) begin
            snap_d[c] = snap_q[c] | free_mask_s;
        end
        if (recover) begin
            free_d = snap_q[recover_idx] | free_mask_s;
        end else begin
            free_d = (free_q & ~(allocatable ? grant_mask_s : {N_PRF{1'b0}})) | free_mask_s;
            if (check) begin
                snap_d[check_idx] = free_d;
            end else begin
                snap_d[check_idx] = snap_d[check_idx];
            end
        end
        free_count_d = popcount_prf(free_d);
    end

    // Live bitmap, snapshots and registered free count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_q       <= reset_map();
            free_count_q <= CNT_W'(N_PRF - N_ARCH);
            for (int c = 0; c < N_CP; c++) begin
                snap_q[c] <= reset_map();
            end
        end else begin
            free_q       <= free_d;
            free_count_q <= free_count_d;
            for (int c = 0; c < N_CP; c++) begin
                snap_q[c] <= snap_d[c];
            end
        end
    end

    assign free_count = free_count_q;

`ifdef FREELIST_DOUBLE_FREE_CHK_EN
    logic             err_q;
    logic             dbl_s;
    logic [N_PRF-1:0] seen_s;
    logic [IDX_W-1:0] chk_idx_s;

    // A free is illegal if the PRF is already free or an earlier lane freed it this cycle.
    always_comb begin
        seen_s    = '0;
        dbl_s     = 1'b0;
        chk_idx_s = '0;
        for (int l = 0; l < RENAME_W; l++) begin
            chk_idx_s = prf_replace[l*IDX_W +: IDX_W];
            if (prf_replace_valid[l] && (chk_idx_s != '0) && (int'(chk_idx_s) < N_PRF)) begin
                if (seen_s[chk_idx_s] || free_q[chk_idx_s]) begin
                    dbl_s = 1'b1;
                end else begin
                    dbl_s = dbl_s;
                end
                seen_s[chk_idx_s] = 1'b1;
            end else begin
                seen_s = seen_s;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | dbl_s;
        end
    end

    assign err_double_free = err_q;
`else
    assign err_double_free = 1'b0;
`endif

endmodule
